// File: rtl/hazard_forwarding_unit_if.sv
// Signal bundle between the 5-stage ARM datapath and its hazard/forwarding controller.
// The datapath side is the master; the controller side is the slave.
interface hazard_forwarding_unit_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       ID_Rn, ID_Rm, ID_Rd;
    logic             ID_use_Rn, ID_use_Rm, ID_use_Rd;
    logic [3:0]       EX_Rd, MEM_Rd, WB_Rd;
    logic             EX_RF_enable, MEM_RF_enable, WB_RF_enable;
    logic             EX_Load_Inst;
    logic             branch_taken;
    logic             mem_busy;

    logic             PC_LE;
    logic             IFID_LE;
    logic             IFID_flush;
    logic             CU_mux_sel;
    logic             pipe_LE;
    logic [1:0]       fwd_A, fwd_B, fwd_C;
    logic [1:0]       state;
    logic             mem_error;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    modport master (
        output ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd,
        output EX_Rd, MEM_Rd, WB_Rd, EX_RF_enable, MEM_RF_enable, WB_RF_enable,
        output EX_Load_Inst, branch_taken, mem_busy,
        input  PC_LE, IFID_LE, IFID_flush, CU_mux_sel, pipe_LE,
        input  fwd_A, fwd_B, fwd_C, state, mem_error, bubble_cnt, flush_cnt
    );

    modport slave (
        input  ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd,
        input  EX_Rd, MEM_Rd, WB_Rd, EX_RF_enable, MEM_RF_enable, WB_RF_enable,
        input  EX_Load_Inst, branch_taken, mem_busy,
        output PC_LE, IFID_LE, IFID_flush, CU_mux_sel, pipe_LE,
        output fwd_A, fwd_B, fwd_C, state, mem_error, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// Pipeline controller: load-use bubbles, branch flushes, memory freeze,
// operand forwarding selects, saturating event counters and a memory timeout flag.
module hazard_forwarding_unit #(
    parameter int WAIT_TIMEOUT = 15,
    parameter int CNT_W        = 16
) (
    input logic                     CLK,
    input logic                     CLR,
    hazard_forwarding_unit_if.slave bus
);
    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        FLUSH      = 2'b10,
        MEM_WAIT   = 2'b11
    } state_t;

    localparam logic [7:0]       TIMEOUT = 8'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_error_q, mem_error_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [2:0] ex_hit, mem_hit, wb_hit;
    logic       load_use;
    logic       pc_le, ifid_le, ifid_flush, cu_mux_sel, pipe_le;

    // R15 reads come from the PC path, so they never forward or stall.
    function automatic logic src_match(input logic used, input logic [3:0] src,
                                       input logic wr_en, input logic [3:0] dst);
        return used && (src != 4'd15) && wr_en && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic ex_m, input logic ex_load,
                                           input logic mem_m, input logic wb_m);
        if (ex_m && !ex_load) return 2'b01;
        else if (mem_m)       return 2'b10;
        else if (wb_m)        return 2'b11;
        else                  return 2'b00;
    endfunction

    // Index 0/1/2 = Rn/Rm/Rd source operand.
    always_comb begin
        ex_hit[0]  = src_match(bus.ID_use_Rn, bus.ID_Rn, bus.EX_RF_enable,  bus.EX_Rd);
        ex_hit[1]  = src_match(bus.ID_use_Rm, bus.ID_Rm, bus.EX_RF_enable,  bus.EX_Rd);
        ex_hit[2]  = src_match(bus.ID_use_Rd, bus.ID_Rd, bus.EX_RF_enable,  bus.EX_Rd);
        mem_hit[0] = src_match(bus.ID_use_Rn, bus.ID_Rn, bus.MEM_RF_enable, bus.MEM_Rd);
        mem_hit[1] = src_match(bus.ID_use_Rm, bus.ID_Rm, bus.MEM_RF_enable, bus.MEM_Rd);
        mem_hit[2] = src_match(bus.ID_use_Rd, bus.ID_Rd, bus.MEM_RF_enable, bus.MEM_Rd);
        wb_hit[0]  = src_match(bus.ID_use_Rn, bus.ID_Rn, bus.WB_RF_enable,  bus.WB_Rd);
        wb_hit[1]  = src_match(bus.ID_use_Rm, bus.ID_Rm, bus.WB_RF_enable,  bus.WB_Rd);
        wb_hit[2]  = src_match(bus.ID_use_Rd, bus.ID_Rd, bus.WB_RF_enable,  bus.WB_Rd);
        load_use   = bus.EX_Load_Inst && (|ex_hit);
    end

    assign bus.fwd_A = fwd_sel(ex_hit[0], bus.EX_Load_Inst, mem_hit[0], wb_hit[0]);
    assign bus.fwd_B = fwd_sel(ex_hit[1], bus.EX_Load_Inst, mem_hit[1], wb_hit[1]);
    assign bus.fwd_C = fwd_sel(ex_hit[2], bus.EX_Load_Inst, mem_hit[2], wb_hit[2]);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            mem_error_q  <= 1'b0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_error_q  <= mem_error_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Freeze outranks load-use, which outranks a taken branch.
    always_comb begin
        state_d      = RUN;
        wait_cnt_d   = '0;
        mem_error_d  = mem_error_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bus.mem_busy) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = (wait_cnt_q >= TIMEOUT) ? TIMEOUT : wait_cnt_q + 8'd1;
            if (wait_cnt_d == TIMEOUT) mem_error_d = 1'b1;
        end else if (load_use) begin
            state_d = LOAD_STALL;
            if (bubble_cnt_q != CNT_MAX) bubble_cnt_d = bubble_cnt_q + 1'b1;
        end else if (bus.branch_taken) begin
            state_d = FLUSH;
            if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_comb begin
        pc_le      = 1'b1;
        ifid_le    = 1'b1;
        pipe_le    = 1'b1;
        cu_mux_sel = 1'b0;
        ifid_flush = 1'b0;
        if (!CLR) begin
            if (bus.mem_busy) begin
                pc_le   = 1'b0;
                ifid_le = 1'b0;
                pipe_le = 1'b0;
            end else if (load_use) begin
                pc_le      = 1'b0;
                ifid_le    = 1'b0;
                cu_mux_sel = 1'b1;
            end else if (bus.branch_taken) begin
                ifid_flush = 1'b1;
            end
        end
    end

    assign bus.PC_LE      = pc_le;
    assign bus.IFID_LE    = ifid_le;
    assign bus.pipe_LE    = pipe_le;
    assign bus.CU_mux_sel = cu_mux_sel;
    assign bus.IFID_flush = ifid_flush;
    assign bus.state      = state_q;
    assign bus.mem_error  = mem_error_q;
    assign bus.bubble_cnt = bubble_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed self-checking bench for hazard_forwarding_unit with hand-computed expectations.
module tb_hazard_forwarding_unit;
    logic CLK;
    logic CLR;
    int   checks;
    int   failures;

    hazard_forwarding_unit_if #(.CNT_W(16)) bus ();

    hazard_forwarding_unit #(
        .WAIT_TIMEOUT(15),
        .CNT_W(16)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // use_m bits = {Rn,Rm,Rd}; en_m bits = {EX,MEM,WB}. Leaves time 2ns for comb to settle.
    task automatic applyStimulus(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                                 input logic [2:0] use_m,
                                 input logic [3:0] ex_rd, input logic [3:0] mem_rd,
                                 input logic [3:0] wb_rd, input logic [2:0] en_m,
                                 input logic load, input logic br, input logic busy);
        bus.ID_Rn         = rn;
        bus.ID_Rm         = rm;
        bus.ID_Rd         = rd;
        bus.ID_use_Rn     = use_m[2];
        bus.ID_use_Rm     = use_m[1];
        bus.ID_use_Rd     = use_m[0];
        bus.EX_Rd         = ex_rd;
        bus.MEM_Rd        = mem_rd;
        bus.WB_Rd         = wb_rd;
        bus.EX_RF_enable  = en_m[2];
        bus.MEM_RF_enable = en_m[1];
        bus.WB_RF_enable  = en_m[0];
        bus.EX_Load_Inst  = load;
        bus.branch_taken  = br;
        bus.mem_busy      = busy;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic busy);
        applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 1'b0, 1'b0, busy);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        CLR      = 1'b1;

        // Reset state, with mem_busy high to show reset overrides the freeze.
        idle(1'b1);
        checkOutput("rst_pc_le", 32'(bus.PC_LE), 1);
        checkOutput("rst_pipe_le", 32'(bus.pipe_LE), 1);
        checkOutput("rst_cu_sel", 32'(bus.CU_mux_sel), 0);
        checkOutput("rst_state", 32'(bus.state), 0);
        checkOutput("rst_bubble", 32'(bus.bubble_cnt), 0);
        checkOutput("rst_mem_error", 32'(bus.mem_error), 0);
        nextCycle();
        CLR = 1'b0;

        idle(1'b0);
        checkOutput("idle_ifid_le", 32'(bus.IFID_LE), 1);
        checkOutput("idle_fwd", 32'({bus.fwd_A, bus.fwd_B, bus.fwd_C}), 0);
        nextCycle();
        checkOutput("idle_state", 32'(bus.state), 0);

        // Forwarding priority and match qualifiers.
        applyStimulus(5, 0, 0, 3'b100, 5, 0, 0, 3'b100, 1'b0, 1'b0, 1'b0);
        checkOutput("fwd_ex", 32'(bus.fwd_A), 1);
        checkOutput("fwd_ex_no_stall", 32'(bus.CU_mux_sel), 0);
        nextCycle();
        applyStimulus(5, 0, 0, 3'b100, 0, 5, 0, 3'b010, 1'b0, 1'b0, 1'b0);
        checkOutput("fwd_mem", 32'(bus.fwd_A), 2);
        nextCycle();
        applyStimulus(5, 0, 0, 3'b100, 0, 0, 5, 3'b001, 1'b0, 1'b0, 1'b0);
        checkOutput("fwd_wb", 32'(bus.fwd_A), 3);
        nextCycle();
        applyStimulus(5, 0, 0, 3'b100, 5, 5, 0, 3'b110, 1'b0, 1'b0, 1'b0);
        checkOutput("fwd_ex_over_mem", 32'(bus.fwd_A), 1);
        nextCycle();
        applyStimulus(15, 0, 0, 3'b100, 15, 15, 15, 3'b111, 1'b0, 1'b0, 1'b0);
        checkOutput("fwd_r15", 32'(bus.fwd_A), 0);
        nextCycle();
        applyStimulus(5, 0, 0, 3'b000, 5, 0, 0, 3'b100, 1'b0, 1'b0, 1'b0);
        checkOutput("fwd_unused", 32'(bus.fwd_A), 0);
        nextCycle();
        applyStimulus(5, 3, 7, 3'b111, 5, 3, 7, 3'b111, 1'b0, 1'b0, 1'b0);
        checkOutput("fwd_abc", 32'({bus.fwd_A, bus.fwd_B, bus.fwd_C}), 32'b01_10_11);
        nextCycle();
        checkOutput("fwd_state", 32'(bus.state), 0);

        // Load in EX whose Rd is not read: no bubble.
        applyStimulus(2, 0, 0, 3'b100, 1, 0, 0, 3'b100, 1'b1, 1'b0, 1'b0);
        checkOutput("load_no_use", 32'(bus.CU_mux_sel), 0);
        nextCycle();

        // Load-use on Rn: one bubble, then MEM forwarding.
        applyStimulus(1, 0, 0, 3'b100, 1, 0, 0, 3'b100, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_ctrl", 32'({bus.PC_LE, bus.IFID_LE, bus.CU_mux_sel, bus.pipe_LE}), 32'b0011);
        nextCycle();
        checkOutput("lu_state", 32'(bus.state), 1);
        checkOutput("lu_bubble", 32'(bus.bubble_cnt), 1);
        applyStimulus(1, 0, 0, 3'b100, 0, 1, 0, 3'b010, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_after_fwd", 32'(bus.fwd_A), 2);
        checkOutput("lu_after_ctrl", 32'({bus.PC_LE, bus.IFID_LE, bus.CU_mux_sel, bus.pipe_LE}), 32'b1101);
        nextCycle();
        checkOutput("lu_after_state", 32'(bus.state), 0);
        checkOutput("lu_after_bubble", 32'(bus.bubble_cnt), 1);

        // Load-use on the store-data source Rd.
        applyStimulus(0, 0, 4, 3'b001, 4, 0, 0, 3'b100, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_rd_sel", 32'(bus.CU_mux_sel), 1);
        nextCycle();
        checkOutput("lu_rd_bubble", 32'(bus.bubble_cnt), 2);

        // Taken branch, then load-use masking a branch.
        applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 1'b0, 1'b1, 1'b0);
        checkOutput("br_ctrl", 32'({bus.IFID_flush, bus.PC_LE, bus.CU_mux_sel}), 32'b110);
        nextCycle();
        checkOutput("br_state", 32'(bus.state), 2);
        checkOutput("br_flush_cnt", 32'(bus.flush_cnt), 1);
        applyStimulus(1, 0, 0, 3'b100, 1, 0, 0, 3'b100, 1'b1, 1'b1, 1'b0);
        checkOutput("lu_br_ctrl", 32'({bus.IFID_flush, bus.CU_mux_sel}), 32'b01);
        nextCycle();
        checkOutput("lu_br_state", 32'(bus.state), 1);
        checkOutput("lu_br_flush_cnt", 32'(bus.flush_cnt), 1);
        checkOutput("lu_br_bubble", 32'(bus.bubble_cnt), 3);

        // mem_busy during a load-use: freeze wins, no bubble.
        applyStimulus(1, 0, 0, 3'b100, 1, 0, 0, 3'b100, 1'b1, 1'b0, 1'b1);
        checkOutput("busy_lu_ctrl", 32'({bus.PC_LE, bus.CU_mux_sel, bus.pipe_LE}), 32'b000);
        nextCycle();
        checkOutput("busy_lu_state", 32'(bus.state), 3);
        checkOutput("busy_lu_bubble", 32'(bus.bubble_cnt), 3);
        idle(1'b0);
        nextCycle();
        checkOutput("busy_lu_release", 32'(bus.state), 0);

        // Short freeze.
        for (int i = 1; i <= 3; i++) begin
            idle(1'b1);
            checkOutput("busy3_les", 32'({bus.PC_LE, bus.IFID_LE, bus.pipe_LE}), 0);
            nextCycle();
            checkOutput("busy3_state", 32'(bus.state), 3);
        end
        checkOutput("busy3_err", 32'(bus.mem_error), 0);
        idle(1'b0);
        nextCycle();
        checkOutput("busy3_release", 32'(bus.state), 0);

        // Timeout exactly at the 15th busy edge, sticky afterwards.
        for (int i = 1; i <= 15; i++) begin
            idle(1'b1);
            nextCycle();
            if (i == 14) checkOutput("busy14_err", 32'(bus.mem_error), 0);
        end
        checkOutput("busy15_err", 32'(bus.mem_error), 1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            nextCycle();
        end
        checkOutput("err_sticky", 32'(bus.mem_error), 1);
        CLR = 1'b1;
        #1;
        checkOutput("clr_err", 32'(bus.mem_error), 0);
        checkOutput("clr_counts", 32'({bus.bubble_cnt, bus.flush_cnt}), 0);
        CLR = 1'b0;

        // Wait counter must restart after a ready cycle.
        for (int i = 0; i < 14; i++) begin
            idle(1'b1);
            nextCycle();
        end
        idle(1'b0);
        nextCycle();
        idle(1'b1);
        nextCycle();
        checkOutput("wait_cnt_clears", 32'(bus.mem_error), 0);
        idle(1'b0);
        nextCycle();

        // Bubble counter saturation over 70000 stalls.
        applyStimulus(1, 0, 0, 3'b100, 1, 0, 0, 3'b100, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 65534; i++) nextCycle();
        checkOutput("bubble_fffe", 32'(bus.bubble_cnt), 32'hFFFE);
        nextCycle();
        checkOutput("bubble_ffff", 32'(bus.bubble_cnt), 32'hFFFF);
        for (int i = 0; i < 4465; i++) nextCycle();
        checkOutput("bubble_no_wrap", 32'(bus.bubble_cnt), 32'hFFFF);

        // CLR in the middle of a timed-out freeze.
        applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 1'b0, 1'b1, 1'b0);
        nextCycle();
        for (int i = 0; i < 16; i++) begin
            idle(1'b1);
            nextCycle();
        end
        checkOutput("pre_clr_state", 32'(bus.state), 3);
        checkOutput("pre_clr_err", 32'(bus.mem_error), 1);
        checkOutput("pre_clr_flush", 32'(bus.flush_cnt), 1);
        CLR = 1'b1;
        #1;
        checkOutput("midclr_state", 32'(bus.state), 0);
        checkOutput("midclr_counts", 32'({bus.bubble_cnt, bus.flush_cnt}), 0);
        checkOutput("midclr_err", 32'(bus.mem_error), 0);
        checkOutput("midclr_les", 32'({bus.PC_LE, bus.IFID_LE, bus.pipe_LE}), 32'b111);
        CLR = 1'b0;
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
